ram_master: RTL and testbench
=============================

Name: ram_master

Overview:
- Initiator for the 32-word single-port synchronous RAM (ports cen, wen, addr, din in; dout out, registered on clk).
- Accepts burst read/write commands on a valid/ready interface and streams write beats in.
- Sequences the RAM control pins, auto-incrementing the address, and returns read data with a valid strobe.
- Sits between the ALU/multiplier datapath and the RAM as the only agent driving the RAM.

Parameters:
- ADDR_W, 5, RAM address width (32 words).
- DATA_W, 32, data word width.
- LEN_W, 5, burst length field width; a burst has cmd_len+1 beats (1..32).

Ports:
- clk  in  1  system clock; all flops on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at the rising edge.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  LEN_W  beats minus 1.
- wr_valid  in  1  write beat available.
- wr_ready  out  1  write beat accepted on wr_valid & wr_ready.
- wr_data  in  DATA_W  write beat data.
- rd_valid  out  1  read beat valid; single-cycle pulse per beat, no backpressure.
- rd_data  out  DATA_W  read beat data.
- rd_last  out  1  high with the final rd_valid of a burst.
- busy  out  1  high when the state is not IDLE or a read beat is still in flight.
- ram_cen  out  1  RAM chip enable (registered).
- ram_wen  out  1  RAM write enable (registered).
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_din  out  DATA_W  RAM write data (registered).
- ram_dout  in  DATA_W  RAM read data; valid the cycle after a read issue.

Behaviour:
- Reset: state=IDLE; ram_cen, ram_wen, ram_addr, ram_din, rd_valid, rd_data, rd_last all 0; read pipe flushed.
- Reset mid-burst: the burst is abandoned immediately. No further RAM access occurs and no rd_valid is produced for in-flight beats.
- States:
  - IDLE: cmd_ready=1, wr_ready=0.
  - RD: issue one read per cycle.
  - WR: wr_ready=1.
  - DRAIN: wait for the read pipe to empty.
- "Issue" means the cycle in which the registered ram_cen=1 is visible on the RAM pins.
- Read burst:
  - Command accepted at edge E0. That edge loads ram_cen=1, ram_wen=0, ram_addr=cmd_addr; beat counter = cmd_len; go to RD.
  - RD, counter>0: each edge loads ram_addr+1 and decrements the counter.
  - RD, counter==0: edge loads ram_cen=0 and goes to DRAIN.
  - Beat i is issued in cycle C0+1+i. ram_dout for it is valid in cycle C0+2+i and is registered into rd_data. rd_valid=1 in cycle C0+3+i (2-cycle issue-to-rd_valid latency).
  - rd_last accompanies beat cmd_len.
  - DRAIN → IDLE on the edge where the final rd_valid is emitted; cmd_ready is high in the cycle after it.
- Write burst:
  - Command accepted at E0: ram_cen<=0, beat counter = cmd_len; go to WR.
  - WR, on each wr_valid&wr_ready edge: ram_cen<=1, ram_wen<=1, ram_addr<=current address, ram_din<=wr_data; address increments.
  - WR, edge with no handshake: ram_cen<=0. wr_valid gaps stall the burst indefinitely.
  - Handshake on the final beat → IDLE. That beat is visible on the RAM pins during the first IDLE cycle.
  - The IDLE edge clears ram_cen/ram_wen unless a new command loads them.
- Write-then-read to the same address: the earliest read issue is the cycle after the write issue, and the RAM has already committed the write, so the read returns the new data.
- Address arithmetic is modulo 2^ADDR_W: 31+1 → 0, with no error.
- cmd_valid while not IDLE: ignored, cmd_ready=0, command fields not sampled.
- wr_valid outside WR: ignored; wr_data is a don't-care.
- ram_wen=0 whenever ram_cen=0.
- ram_din holds its last value when not writing.

Decomposition:
- Package ram_master_pkg holds:
  - ADDR_W, DATA_W, LEN_W.
  - State encoding localparams ST_IDLE, ST_RD, ST_WR, ST_DRAIN.
- Sub-module ram_rd_pipe, which holds:
  - a 2-stage valid/last shift register fed by read issues;
  - the rd_data capture of ram_dout;
  - a flush on reset;
  - an "empty" flag for DRAIN and busy.

Test Plan:
- Write burst addr=1, len=2, beats 32'h1111_1111, 32'h2222_2222, 32'h3333_3333 with wr_valid held high → ram_cen=ram_wen=1 on 3 consecutive cycles, addr 1,2,3, matching din; then cen=0.
- Read burst addr=1, len=2 accepted at C0 → ram_cen=1, wen=0 in C1..C3 (addr 1,2,3); rd_valid in C3..C5 with data 1111_1111, 2222_2222, 3333_3333; rd_last only in C5; cmd_ready high in C6.
- Wrap: write addr=31, len=1, data A5A5_A5A5, 5A5A_5A5A; read back addr=31, len=1 → ram_addr 31 then 0; rd_data A5A5_A5A5 then 5A5A_5A5A.
- Write with wr_valid low for 2 cycles between beats → ram_cen low during the gap, no extra writes, burst completes, busy low only after the final beat.
- cmd_valid asserted mid-read → cmd_ready=0, no extra RAM access; the command is accepted only once IDLE.
- reset_n low for 1 cycle during a 4-beat read after beat 1 issues → all outputs 0 immediately, no further rd_valid, IDLE and cmd_ready=1 after release.

Source files
------------

// File: rtl/ram_master_pkg.sv
// ram_master_pkg
//   Shared sizing constants and FSM state encoding for the RAM initiator
//   (ram_master) and its read-return pipe (ram_rd_pipe).
//
//   ADDR_W : RAM address width (32 words)
//   DATA_W : RAM data word width
//   LEN_W  : burst length field width; a burst carries cmd_len+1 beats
package ram_master_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_WR    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe
//   Tracks read issues on their way through the synchronous RAM and turns
//   them into the rd_valid / rd_last / rd_data return strobe, two cycles
//   after the issue cycle.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset; flushes every beat in flight
//   issue      in   a read is on the RAM pins this cycle
//   issue_last in   the read on the pins is the final beat of its burst
//   ram_dout   in   RAM read data, valid the cycle after the issue
//   rd_valid   out  one-cycle pulse per returned beat
//   rd_last    out  marks the final beat of a burst
//   rd_data    out  returned beat data (holds between beats)
//   empty      out  no beat is left that has yet to reach rd_valid
module ram_rd_pipe
    import ram_master_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue,
    input  logic              issue_last,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              rd_valid,
    output logic              rd_last,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty
);

    logic vld_p1;
    logic last_p1;

    // Stage p1: the issued read is now being answered on ram_dout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= issue;
            last_p1 <= issue & issue_last;
        end
    end

    // Stage p2: ram_dout captured and presented with its strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= vld_p1;
            rd_last  <= last_p1;
            if (vld_p1) begin
                rd_data <= ram_dout;
            end
        end
    end

    // The beat in stage p2 is already on the outputs, so only p1 counts
    // as still in flight.
    assign empty = ~vld_p1;

endmodule

// File: rtl/ram_master.sv
// ram_master
//   Sole initiator of the 32-word single-port synchronous RAM. Accepts burst
//   read/write commands on a valid/ready handshake, streams write beats in,
//   drives registered RAM control pins with auto-incrementing addresses and
//   returns read beats with a valid strobe two cycles after each issue.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   cmd_valid  in   command request
//   cmd_ready  out  command accepted on cmd_valid & cmd_ready (IDLE only)
//   cmd_we     in   1 = write burst, 0 = read burst
//   cmd_addr   in   burst start address
//   cmd_len    in   beats minus one
//   wr_valid   in   write beat available
//   wr_ready   out  write beat accepted on wr_valid & wr_ready
//   wr_data    in   write beat data
//   rd_valid   out  read beat valid, one-cycle pulse, no backpressure
//   rd_data    out  read beat data
//   rd_last    out  final beat of a read burst
//   busy       out  FSM not IDLE or a read beat still in flight
//   ram_cen    out  RAM chip enable (registered)
//   ram_wen    out  RAM write enable (registered)
//   ram_addr   out  RAM address (registered)
//   ram_din    out  RAM write data (registered)
//   ram_dout   in   RAM read data, valid the cycle after a read issue
module ram_master
    import ram_master_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              ram_cen,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic              cen_nxt;
    logic              wen_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] din_nxt;
    logic              rd_issue;
    logic              rd_issue_last;
    logic              pipe_empty;

    assign cmd_ready = (state == ST_IDLE);
    assign wr_ready  = (state == ST_WR);
    assign busy      = (state != ST_IDLE) | ~pipe_empty;

    // A read is "issued" in the cycle its registered enable sits on the pins.
    // In RD the counter reaches zero exactly while the final beat is on the pins.
    assign rd_issue      = ram_cen & ~ram_wen;
    assign rd_issue_last = rd_issue & (state == ST_RD) & (cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Enable defaults to 0 each cycle so the pins only carry an access in the
    // cycle the FSM asks for it; ram_wen is only ever raised together with
    // ram_cen. Address arithmetic wraps naturally at 2^ADDR_W.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        wr_addr_nxt = wr_addr;
        cen_nxt     = 1'b0;
        wen_nxt     = 1'b0;
        addr_nxt    = ram_addr;
        din_nxt     = ram_din;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cnt_nxt = cmd_len;
                    if (cmd_we) begin
                        wr_addr_nxt = cmd_addr;
                        state_nxt   = ST_WR;
                    end else begin
                        cen_nxt   = 1'b1;
                        addr_nxt  = cmd_addr;
                        state_nxt = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (cnt != '0) begin
                    cen_nxt  = 1'b1;
                    addr_nxt = ram_addr + 1'b1;
                    cnt_nxt  = cnt - 1'b1;
                end else begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_WR: begin
                if (wr_valid) begin
                    cen_nxt     = 1'b1;
                    wen_nxt     = 1'b1;
                    addr_nxt    = wr_addr;
                    din_nxt     = wr_data;
                    wr_addr_nxt = wr_addr + 1'b1;
                    if (cnt == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave on the edge where the final beat is on rd_valid.
                if (pipe_empty) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            wr_addr <= '0;
        end else begin
            cnt     <= cnt_nxt;
            wr_addr <= wr_addr_nxt;
        end
    end

    // Stage p0: RAM pins registered; this is the issue cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_cen  <= 1'b0;
            ram_wen  <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_cen  <= cen_nxt;
            ram_wen  <= wen_nxt;
            ram_addr <= addr_nxt;
            ram_din  <= din_nxt;
        end
    end

    ram_rd_pipe u_rd_pipe (
        .clk        (clk),
        .reset_n    (reset_n),
        .issue      (rd_issue),
        .issue_last (rd_issue_last),
        .ram_dout   (ram_dout),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last),
        .rd_data    (rd_data),
        .empty      (pipe_empty)
    );

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master
//   Bench for ram_master with a behavioural 32-word synchronous RAM.
//   Expected RAM accesses and read returns (with their cycle numbers) are
//   queued as stimulus is driven and popped by a negedge monitor.
module tb_ram_master;
    import ram_master_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;
    logic              ram_cen;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout = '0;

    logic [DATA_W-1:0] ram_mem [32] = '{default: '0};
    logic [DATA_W-1:0] ref_mem [32];
    logic [DATA_W-1:0] beat_data [32];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t wr_q[$];
    exp_t iss_q[$];
    exp_t rd_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_master dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .ram_cen   (ram_cen),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Behavioural single-port synchronous RAM.
    always @(posedge clk) begin
        if (ram_cen) begin
            if (ram_wen) ram_mem[ram_addr] <= ram_din;
            else         ram_dout <= ram_mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: every RAM access and every read return must match the head
    // of its queue, including the cycle it appears in.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            if (ram_wen) chk("wen_needs_cen", ram_cen, 1);
            if (rd_last) chk("last_needs_valid", rd_valid, 1);
            if (ram_cen && ram_wen) begin
                if (wr_q.size() == 0) chk("wr_unexpected", {ram_addr, ram_din}, 0);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_cyc", cyc, e.cyc);
                    chk("wr_addr", ram_addr, e.addr);
                    chk("wr_din", ram_din, e.data);
                end
            end
            if (ram_cen && !ram_wen) begin
                if (iss_q.size() == 0) chk("rd_issue_unexpected", ram_addr, 6'h3f);
                else begin
                    e = iss_q.pop_front();
                    chk("rd_issue_cyc", cyc, e.cyc);
                    chk("rd_issue_addr", ram_addr, e.addr);
                end
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) chk("rd_valid_unexpected", rd_data, 64'hffff_ffff_ffff_ffff);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_cyc", cyc, e.cyc);
                    chk("rd_data", rd_data, e.data);
                    chk("rd_last", rd_last, e.last);
                end
            end
        end
    end

    task automatic send_cmd(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [LEN_W-1:0] len, output int c0);
        int n;
        logic [ADDR_W-1:0] a;
        n = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("cmd_accept_tmo", cmd_ready, 1);
        c0 = cyc;
        if (!we) begin
            for (int i = 0; i <= int'(len); i++) begin
                a = addr + ADDR_W'(i);
                iss_q.push_back('{c0 + 1 + i, a, DATA_W'(0), 1'b0});
                rd_q.push_back('{c0 + 3 + i, a, ref_mem[a], (i == int'(len))});
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic write_beats(input logic [ADDR_W-1:0] addr, input int n, input int gap);
        int t;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < n; i++) begin
            t = 0;
            wr_valid = 1'b1;
            wr_data  = beat_data[i];
            @(negedge clk);
            while (!wr_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!wr_ready) chk("wr_ready_tmo", wr_ready, 1);
            a = addr + ADDR_W'(i);
            wr_q.push_back('{cyc + 1, a, beat_data[i], 1'b0});
            ref_mem[a] = beat_data[i];
            @(posedge clk);
            #1;
            if (gap > 0 && i < n - 1) begin
                wr_valid = 1'b0;
                wr_data  = 32'hBAD0_BAD0;
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk("busy_in_gap", busy, 1);
                    chk("wr_ready_in_gap", wr_ready, 1);
                    @(posedge clk);
                    #1;
                end
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_ready(output int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("idle_tmo", cmd_ready, 1);
        c = cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cen", ram_cen, 0);
        chk("rst_wen", ram_wen, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Stray write beats while IDLE must not reach the RAM
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        wr_valid = 1'b0;

        // Write burst addr 1, len 2, wr_valid held
        beat_data[0] = 32'h1111_1111;
        beat_data[1] = 32'h2222_2222;
        beat_data[2] = 32'h3333_3333;
        send_cmd(1'b1, 5'd1, 5'd2, c0);
        write_beats(5'd1, 3, 0);
        chk("busy_after_wr1", busy, 0);

        // Read burst addr 1, len 2; cmd_ready returns in C0+6
        send_cmd(1'b0, 5'd1, 5'd2, c0);
        wait_ready(c1);
        chk("rd_ready_cyc", c1, c0 + 6);

        // Address wrap, read issued right behind the final write
        beat_data[0] = 32'hA5A5_A5A5;
        beat_data[1] = 32'h5A5A_5A5A;
        send_cmd(1'b1, 5'd31, 5'd1, c0);
        write_beats(5'd31, 2, 0);
        send_cmd(1'b0, 5'd31, 5'd1, c0);
        wait_ready(c1);

        // Write with 2-cycle wr_valid gaps, then immediate read-back
        beat_data[0] = 32'h0808_0808;
        beat_data[1] = 32'h0909_0909;
        beat_data[2] = 32'h0A0A_0A0A;
        send_cmd(1'b1, 5'd8, 5'd2, c0);
        write_beats(5'd8, 3, 2);
        chk("busy_after_gap_wr", busy, 0);
        send_cmd(1'b0, 5'd8, 5'd2, c0);
        wait_ready(c1);

        // Command held during a 4-beat read is only taken once IDLE
        send_cmd(1'b0, 5'd8, 5'd3, c0);
        send_cmd(1'b1, 5'd20, 5'd0, c1);
        chk("cmd_held_off", c1, c0 + 7);
        beat_data[0] = 32'hCAFE_0014;
        write_beats(5'd20, 1, 0);
        send_cmd(1'b0, 5'd20, 5'd0, c0);
        wait_ready(c1);
        chk("rd_len0_ready_cyc", c1, c0 + 4);

        // Reset for one cycle during a 4-beat read, after beat 1 issues
        send_cmd(1'b0, 5'd1, 5'd3, c0);
        @(negedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        wr_q.delete();
        iss_q.delete();
        rd_q.delete();
        #1;
        chk("mid_rst_cen", ram_cen, 0);
        chk("mid_rst_wen", ram_wen, 0);
        chk("mid_rst_addr", ram_addr, 0);
        chk("mid_rst_din", ram_din, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_rd_last", rd_last, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        @(posedge clk);
        #1;

        // Operation resumes after reset
        send_cmd(1'b0, 5'd31, 5'd0, c0);
        wait_ready(c1);

        chk("wr_q_left", wr_q.size(), 0);
        chk("iss_q_left", iss_q.size(), 0);
        chk("rd_q_left", rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
